// File: rtl/excp_seq_if.sv
// Exception sequencer bus: request/PC/memory inputs from the control unit and
// the EPC/PC/mux-select results returned to it. The control unit is the master.
interface excp_seq_if;
   logic        excp_opcode;
   logic        excp_overflow;
   logic        excp_div0;
   logic [31:0] pc_in;
   logic [31:0] mem_data_in;
   logic [2:0]  mux_sel;
   logic [31:0] epc_out;
   logic        epc_wr;
   logic [31:0] pc_out;
   logic        pc_wr;
   logic        busy;
   logic        done;
   logic [1:0]  cause;

   modport master (
      output excp_opcode, excp_overflow, excp_div0, pc_in, mem_data_in,
      input  mux_sel, epc_out, epc_wr, pc_out, pc_wr, busy, done, cause
   );

   modport slave (
      input  excp_opcode, excp_overflow, excp_div0, pc_in, mem_data_in,
      output mux_sel, epc_out, epc_wr, pc_out, pc_wr, busy, done, cause
   );
endinterface

// File: rtl/excp_seq.sv
// Exception sequencer: on an invalid-opcode / overflow / divide-by-zero request
// it saves EPC = PC - 4, steers the address mux to the handler vector
// (253/254/255), waits MEM_LAT cycles for memory and loads the zero-extended
// handler byte into PC.
// Optional feature macro: EXCP_CAUSE_REG_EN -- when defined the latched cause is
// driven on the cause output; otherwise cause reads 00 (still tracked inside).
module excp_seq #(
   parameter int unsigned MEM_LAT = 2   // memory read latency, 1..15
) (
   input logic     clk,
   input logic     reset,
   excp_seq_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SAVE,
      S_WAIT,
      S_LOAD,
      S_DONE
   } state_t;

   localparam logic [3:0] WAIT_INIT = 4'(MEM_LAT - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q,   cnt_d;
   logic [1:0]  cause_q, cause_d;
   logic [31:0] epc_q,   epc_d;
   logic [31:0] pc_q,    pc_d;
   logic        req_any;
   logic [2:0]  vector_sel;
   logic        unused_mem_hi;

   // only the low byte of memory data is the handler address
   assign unused_mem_hi = ^bus.mem_data_in[31:8];

   assign req_any = bus.excp_opcode | bus.excp_overflow | bus.excp_div0;

   // state, counter and result registers; reset returns everything to zero
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         cause_q <= '0;
         epc_q   <= '0;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
         epc_q   <= epc_d;
         pc_q    <= pc_d;
      end
   end

   // next-state logic: cause/EPC captured in IDLE, handler byte at the last WAIT
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      epc_d   = epc_q;
      pc_d    = pc_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_any) begin
               if (bus.excp_opcode)        cause_d = 2'b01;
               else if (bus.excp_overflow) cause_d = 2'b10;
               else                        cause_d = 2'b11;
               epc_d   = bus.pc_in - 32'd4;
               state_d = S_SAVE;
            end
         end
         S_SAVE: begin
            cnt_d   = WAIT_INIT;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               pc_d    = {24'b0, bus.mem_data_in[7:0]};
               state_d = S_LOAD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_LOAD:  state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // vector selector for the latched cause
   always_comb begin
      vector_sel = 3'b000;
      unique case (cause_q)
         2'b01:   vector_sel = 3'b010;
         2'b10:   vector_sel = 3'b011;
         2'b11:   vector_sel = 3'b100;
         default: vector_sel = 3'b000;
      endcase
   end

   // Moore outputs decoded from the state register
   always_comb begin
      bus.mux_sel = 3'b000;
      bus.epc_wr  = 1'b0;
      bus.pc_wr   = 1'b0;
      bus.done    = 1'b0;
      bus.busy    = (state_q != S_IDLE);
      unique case (state_q)
         S_SAVE: begin
            bus.mux_sel = vector_sel;
            bus.epc_wr  = 1'b1;
         end
         S_WAIT:  bus.mux_sel = vector_sel;
         S_LOAD: begin
            bus.mux_sel = vector_sel;
            bus.pc_wr   = 1'b1;
         end
         S_DONE:  bus.done = 1'b1;
         default: ;
      endcase
   end

   assign bus.epc_out = epc_q;
   assign bus.pc_out  = pc_q;

`ifdef EXCP_CAUSE_REG_EN
   assign bus.cause = cause_q;
`else
   assign bus.cause = 2'b00;
`endif

endmodule

// File: tb/tb_excp_seq.sv
// Testbench for excp_seq: two instances (MEM_LAT=2 and MEM_LAT=1) share the same
// stimulus. A cycle-offset reference model checks every output each cycle, a
// table of directed scenarios checks the documented timeline with constants,
// and hand-written sequences cover re-entry while busy and reset mid-sequence.
module tb_excp_seq;

   typedef struct packed {
      logic [2:0]  mux_sel;
      logic [31:0] epc_out;
      logic        epc_wr;
      logic [31:0] pc_out;
      logic        pc_wr;
      logic        busy;
      logic        done;
      logic [1:0]  cause;
   } outs_t;

   typedef struct {
      logic        op, ovf, dz;
      logic [31:0] pc_in;
      logic [31:0] mem;
      logic [2:0]  exp_mux;
      logic [1:0]  exp_cause;
      logic [31:0] exp_epc;
      logic [31:0] exp_pc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        op, ovf, dz;
   logic [31:0] pc_in, mem;

   int n_chk  = 0;
   int n_fail = 0;

   excp_seq_if if2 ();
   excp_seq_if if1 ();

   assign if2.excp_opcode   = op;
   assign if2.excp_overflow = ovf;
   assign if2.excp_div0     = dz;
   assign if2.pc_in         = pc_in;
   assign if2.mem_data_in   = mem;
   assign if1.excp_opcode   = op;
   assign if1.excp_overflow = ovf;
   assign if1.excp_div0     = dz;
   assign if1.pc_in         = pc_in;
   assign if1.mem_data_in   = mem;

   excp_seq #(.MEM_LAT(2)) dut2 (.clk(clk), .reset(rst), .bus(if2));
   excp_seq #(.MEM_LAT(1)) dut1 (.clk(clk), .reset(rst), .bus(if1));

   always #5 clk = ~clk;

   outs_t act [2];
   assign act[0] = {if2.mux_sel, if2.epc_out, if2.epc_wr, if2.pc_out,
                    if2.pc_wr, if2.busy, if2.done, if2.cause};
   assign act[1] = {if1.mux_sel, if1.epc_out, if1.epc_wr, if1.pc_out,
                    if1.pc_wr, if1.busy, if1.done, if1.cause};

   // reference model: t = cycles since the triggering edge (0 = idle)
   int          lat [2] = '{2, 1};
   int          t   [2];
   logic [31:0] m_epc [2];
   logic [31:0] m_pc  [2];
   logic [1:0]  m_cause [2];

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            t[k] = 0; m_epc[k] = '0; m_pc[k] = '0; m_cause[k] = '0;
         end else if (t[k] == 0) begin
            if (op || ovf || dz) begin
               t[k]       = 1;
               m_cause[k] = op ? 2'd1 : (ovf ? 2'd2 : 2'd3);
               m_epc[k]   = pc_in - 32'd4;
            end
         end else begin
            if (t[k] == lat[k] + 1) m_pc[k] = {24'b0, mem[7:0]};
            t[k] = (t[k] == lat[k] + 3) ? 0 : t[k] + 1;
         end
      end
   endtask

   function automatic outs_t expect_of(int k);
      outs_t e;
      e.busy    = (t[k] != 0);
      e.epc_wr  = (t[k] == 1);
      e.pc_wr   = (t[k] == lat[k] + 2);
      e.done    = (t[k] == lat[k] + 3);
      e.mux_sel = (t[k] >= 1 && t[k] <= lat[k] + 2) ? 3'(m_cause[k] + 2'd1) : 3'b000;
      e.epc_out = m_epc[k];
      e.pc_out  = m_pc[k];
`ifdef EXCP_CAUSE_REG_EN
      e.cause   = m_cause[k];
`else
      e.cause   = 2'b00;
`endif
      return e;
   endfunction

   task automatic chk(string name, logic [79:0] a, logic [79:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, a, e, $time);
      end
   endtask

   task automatic compare_all();
      outs_t e;
      for (int k = 0; k < 2; k++) begin
         e = expect_of(k);
         chk($sformatf("L%0d model outputs", lat[k]), 80'(act[k]), 80'(e));
      end
   endtask

   // one clock: model follows the edge, outputs checked 1 time unit later
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic clear_req();
      op = 1'b0; ovf = 1'b0; dz = 1'b0;
   endtask

   vec_t vecs [4];
   logic [1:0] ec;
   int cnt_pcwr, cnt_epcwr, cnt_done, bad_mux;

   initial begin
      vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_00A5, 3'b010, 2'b01, 32'h0000_003C, 32'h0000_00A5};
      vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0077, 3'b011, 2'b10, 32'h0000_00FC, 32'h0000_0077};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h1234_56FF, 3'b100, 2'b11, 32'hFFFF_FFFC, 32'h0000_00FF};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'hABCD_EF01, 3'b010, 2'b01, 32'h7FFF_FFFC, 32'h0000_0001};

      rst = 1'b1; clear_req(); pc_in = '0; mem = '0;
      for (int k = 0; k < 2; k++) begin
         t[k] = 0; m_epc[k] = '0; m_pc[k] = '0; m_cause[k] = '0;
      end
      step(); step();
      chk("reset L2 all zero", 80'(act[0]), 80'(0));
      chk("reset L1 all zero", 80'(act[1]), 80'(0));
      #2 rst = 1'b0;
      step();

      // directed table: cycle 0 is the request edge
      for (int i = 0; i < 4; i++) begin
`ifdef EXCP_CAUSE_REG_EN
         ec = vecs[i].exp_cause;
`else
         ec = 2'b00;
`endif
         op = vecs[i].op; ovf = vecs[i].ovf; dz = vecs[i].dz;
         pc_in = vecs[i].pc_in; mem = vecs[i].mem;
         step();                                   // cycle 1: SAVE
         clear_req();
         chk($sformatf("v%0d c1 epc_wr", i),  80'(if2.epc_wr),  80'(1));
         chk($sformatf("v%0d c1 epc_out", i), 80'(if2.epc_out), 80'(vecs[i].exp_epc));
         chk($sformatf("v%0d c1 mux_sel", i), 80'(if2.mux_sel), 80'(vecs[i].exp_mux));
         chk($sformatf("v%0d c1 cause", i),   80'(if2.cause),   80'(ec));
         step();                                   // cycle 2
         chk($sformatf("v%0d c2 mux_sel", i), 80'(if2.mux_sel), 80'(vecs[i].exp_mux));
         step();                                   // cycle 3
         chk($sformatf("v%0d L1 c3 pc_wr", i),  80'(if1.pc_wr),  80'(1));
         chk($sformatf("v%0d L1 c3 pc_out", i), 80'(if1.pc_out), 80'(vecs[i].exp_pc));
         chk($sformatf("v%0d c3 pc_wr", i),     80'(if2.pc_wr),  80'(0));
         step();                                   // cycle 4
         chk($sformatf("v%0d c4 pc_wr", i),   80'(if2.pc_wr),   80'(1));
         chk($sformatf("v%0d c4 pc_out", i),  80'(if2.pc_out),  80'(vecs[i].exp_pc));
         chk($sformatf("v%0d c4 mux_sel", i), 80'(if2.mux_sel), 80'(vecs[i].exp_mux));
         chk($sformatf("v%0d L1 c4 done", i), 80'(if1.done),    80'(1));
         step();                                   // cycle 5
         chk($sformatf("v%0d c5 done", i),    80'(if2.done),    80'(1));
         chk($sformatf("v%0d c5 mux_sel", i), 80'(if2.mux_sel), 80'(0));
         step();                                   // cycle 6
         chk($sformatf("v%0d c6 busy", i),    80'(if2.busy),    80'(0));
         chk($sformatf("v%0d c6 cause held", i), 80'(if2.cause), 80'(ec));
      end

      // re-entry while busy: div0 at cycle 0, opcode pulse at cycle 2
      dz = 1'b1; pc_in = 32'h0000_2000; mem = 32'h0000_0033;
      cnt_pcwr = 0; cnt_epcwr = 0; bad_mux = 0;
      for (int c = 1; c <= 9; c++) begin
         step();
         clear_req();
         if (c == 2) op = 1'b1;
         cnt_pcwr  += int'(if2.pc_wr);
         cnt_epcwr += int'(if2.epc_wr);
         if (if2.mux_sel != 3'b100 && if2.mux_sel != 3'b000) bad_mux++;
      end
      chk("reentry single pc_wr", 80'(cnt_pcwr), 80'(1));
      chk("reentry single epc_wr", 80'(cnt_epcwr), 80'(1));
      chk("reentry mux only 100", 80'(bad_mux), 80'(0));

      // reset asserted during cycle 3
      dz = 1'b1; pc_in = 32'h0000_0400; mem = 32'h0000_0044;
      step(); clear_req();                         // cycle 1
      step();                                      // cycle 2
      step();                                      // cycle 3
      rst = 1'b1;
      step();                                      // cycle 4: idle
      chk("midreset L2 all zero", 80'(act[0]), 80'(0));
      chk("midreset L1 all zero", 80'(act[1]), 80'(0));
      rst = 1'b0;
      cnt_pcwr = 0; cnt_done = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         cnt_pcwr += int'(if2.pc_wr);
         cnt_done += int'(if2.done);
      end
      chk("midreset no pc_wr", 80'(cnt_pcwr), 80'(0));
      chk("midreset no done", 80'(cnt_done), 80'(0));

      // randomized stimulus against the model
      for (int c = 0; c < 500; c++) begin
         op    = ($urandom_range(0, 5) == 0);
         ovf   = ($urandom_range(0, 5) == 0);
         dz    = ($urandom_range(0, 5) == 0);
         rst   = ($urandom_range(0, 49) == 0);
         pc_in = $urandom;
         mem   = $urandom;
         step();
      end
      rst = 1'b0; clear_req();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
